// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern, hex glyphs, width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low glyphs, bit 0 = segment a; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational. Backpressure: none.
// Glyphs 0-F, with b and d in lowercase.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPHS[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-seg scan driver: prescaled digit scan, frame snapshot, LZ blanking, PWM dimming.
// Latency: outputs registered, one cycle after any idx/pwm/snapshot change.
// Backpressure: none; free-running scan, hold only freezes the snapshot.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int BRIGHT_W = 4
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic                  hold,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [DIGITS-1:0]     en,
    output logic [6:0]            dis,
    output logic                  dp_n,
    output logic                  frame_tick
);

    localparam int PW = clog2(SCAN_DIV);
    localparam int IW = clog2(DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]       pre_cnt;
    logic [IW-1:0]       idx;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [4*DIGITS-1:0] snap_data;
    logic [DIGITS-1:0]   snap_dp;
    logic                snap_blz;
    logic                slot_end;
    logic                frame_wrap;

    assign slot_end   = (pre_cnt == PRE_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            pre_cnt    <= '0;
            idx        <= '0;
            pwm_cnt    <= '0;
            frame_tick <= 1'b0;
            snap_data  <= '0;
            snap_dp    <= '0;
            snap_blz   <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + BRIGHT_W'(1);
            frame_tick <= frame_wrap;
            if (slot_end) begin
                pre_cnt <= '0;
                idx     <= frame_wrap ? '0 : idx + IW'(1);
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
            // Snapshot only at the frame boundary so a frame never tears.
            if (frame_wrap && !hold) begin
                snap_data <= data;
                snap_dp   <= dp;
                snap_blz  <= blank_lz;
            end
        end
    end

    // Digit i is blanked when it and every more significant nibble is zero.
    logic [DIGITS-1:0] blank;
    logic              upper_zero;

    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (snap_data[4*i +: 4] == 4'h0);
            blank[i]   = snap_blz && upper_zero;
        end
    end

    logic [3:0] cur_nib;
    logic [6:0] cur_seg;
    logic       lit;

    assign cur_nib = snap_data[{idx, 2'b00} +: 4];
    assign lit     = (pwm_cnt <= bright) && !blank[idx];

    seg7_hex_dec u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            en   <= '1;
            dis  <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            en   <= lit ? ~(DIGITS'(1) << idx) : '1;
            dis  <= lit ? cur_seg : SEG_OFF;
            dp_n <= lit ? ~snap_dp[idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl at DIGITS=8, SCAN_DIV=4, BRIGHT_W=2.
module tb_seg7_scan_ctrl;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;
    localparam int BRIGHT_W = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        sclk     = 1'b0;
    logic        clk_run  = 1'b0;
    logic        reset    = 1'b0;
    logic [31:0] data     = 32'h0;
    logic [7:0]  dp       = 8'h0;
    logic        blank_lz = 1'b0;
    logic        hold     = 1'b0;
    logic [1:0]  bright   = 2'd3;
    logic [7:0]  en;
    logic [6:0]  dis;
    logic        dp_n;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] en;
        logic [6:0] dis;
        logic       dp_n;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 if (clk_run) sclk = ~sclk;

    seg7_scan_ctrl #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BRIGHT_W (BRIGHT_W)
    ) dut (
        .sclk       (sclk),
        .reset      (reset),
        .data       (data),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .hold       (hold),
        .bright     (bright),
        .en         (en),
        .dis        (dis),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    // Expected outputs for the FRAME samples following a frame_tick sample.
    function automatic void push_frame(input logic [31:0] d, input logic [7:0] dpv,
                                       input logic blz, input logic [1:0] br);
        exp_t       x;
        int         dg;
        int         ph;
        logic [3:0] nib;
        logic       lit;
        for (int j = 1; j <= FRAME; j++) begin
            dg  = (j - 1) / SCAN_DIV;
            ph  = (j - 1) % SCAN_DIV;
            nib = d[4*dg +: 4];
            lit = (ph <= int'(br)) && !(blz && dg > 0 && (d >> (4*dg)) == 32'h0);
            x.en   = lit ? ~(8'h01 << dg) : 8'hFF;
            x.dis  = lit ? GLYPH[nib] : 7'h7F;
            x.dp_n = lit ? ~dpv[dg] : 1'b1;
            x.tick = (j == FRAME);
            sb.push_back(x);
        end
    endfunction

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge sclk); #1;
            n++;
        end while (!frame_tick && n < 3 * FRAME);
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL %s_tick_timeout frame_tick=%b required=1", tag, frame_tick);
        end
    endtask

    task automatic test_reset();
        int n;
        #20 reset = 1'b1;
        #3;
        checks++;
        if ({en, dis, dp_n, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_async en=%h dis=%h dp_n=%b tick=%b required FF/7F/1/0",
                     en, dis, dp_n, frame_tick);
        end
        clk_run = 1'b1;
        repeat (3) @(posedge sclk);
        #1 reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(posedge sclk); #1;
                n++;
            end while (!frame_tick && n < 3 * FRAME);
            checks++;
            if (n != FRAME || frame_tick !== 1'b1) begin
                failures++;
                $display("FAIL reset_tick_period%0d cycles=%0d tick=%b required cycles=%0d tick=1",
                         k, n, frame_tick, FRAME);
            end
        end
    endtask

    task automatic test_basic();
        data = 32'h12345678; dp = 8'h08; blank_lz = 1'b0; bright = 2'd3; hold = 1'b0;
        wait_tick("basic");
        push_frame(data, dp, blank_lz, bright);
        for (int j = 1; j <= FRAME; j++) begin
            @(posedge sclk); #1;
            e = sb.pop_front();
            checks++;
            if ({en, dis, dp_n, frame_tick} !== e) begin
                failures++;
                $display("FAIL basic j=%0d en=%h dis=%h dp_n=%b tick=%b required %h/%h/%b/%b",
                         j, en, dis, dp_n, frame_tick, e.en, e.dis, e.dp_n, e.tick);
            end
        end
    endtask

    task automatic test_leading_zero();
        data = 32'h000000A0; dp = 8'h00; blank_lz = 1'b1; bright = 2'd3;
        wait_tick("lz");
        push_frame(data, dp, blank_lz, bright);
        for (int j = 1; j <= FRAME; j++) begin
            @(posedge sclk); #1;
            e = sb.pop_front();
            checks++;
            if ({en, dis, dp_n, frame_tick} !== e) begin
                failures++;
                $display("FAIL lz j=%0d en=%h dis=%h dp_n=%b tick=%b required %h/%h/%b/%b",
                         j, en, dis, dp_n, frame_tick, e.en, e.dis, e.dp_n, e.tick);
            end
        end
    endtask

    task automatic test_hold();
        data = 32'h11111111; dp = 8'h00; blank_lz = 1'b0; bright = 2'd3; hold = 1'b0;
        wait_tick("hold");
        hold = 1'b1;
        data = 32'h22222222;
        repeat (4) push_frame(32'h11111111, 8'h00, 1'b0, 2'd3);
        push_frame(32'h22222222, 8'h00, 1'b0, 2'd3);
        for (int j = 1; j <= 5 * FRAME; j++) begin
            @(posedge sclk); #1;
            e = sb.pop_front();
            checks++;
            if ({en, dis, dp_n, frame_tick} !== e) begin
                failures++;
                $display("FAIL hold j=%0d en=%h dis=%h dp_n=%b tick=%b required %h/%h/%b/%b",
                         j, en, dis, dp_n, frame_tick, e.en, e.dis, e.dp_n, e.tick);
            end
            // Released just after a frame start: the following frame must still show 1s.
            if (j == 3 * FRAME) hold = 1'b0;
        end
    endtask

    task automatic test_brightness();
        data = 32'h12345678; dp = 8'h00; blank_lz = 1'b0; bright = 2'd0;
        wait_tick("bright");
        push_frame(data, dp, 1'b0, 2'd0);
        push_frame(data, dp, 1'b0, 2'd2);
        for (int j = 1; j <= 2 * FRAME; j++) begin
            @(posedge sclk); #1;
            e = sb.pop_front();
            checks++;
            if ({en, dis, dp_n, frame_tick} !== e) begin
                failures++;
                $display("FAIL bright j=%0d en=%h dis=%h dp_n=%b tick=%b required %h/%h/%b/%b",
                         j, en, dis, dp_n, frame_tick, e.en, e.dis, e.dp_n, e.tick);
            end
            if (j == FRAME) bright = 2'd2;
        end
    endtask

    task automatic test_reset_mid();
        data = 32'h12345678; dp = 8'h00; blank_lz = 1'b0; bright = 2'd3;
        wait_tick("rstmid");
        repeat (22) @(posedge sclk);
        #1;
        checks++;
        if (en !== 8'hDF) begin
            failures++;
            $display("FAIL rstmid_digit5 en=%h required DF", en);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({en, dis, dp_n, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rstmid_async en=%h dis=%h dp_n=%b tick=%b required FF/7F/1/0",
                     en, dis, dp_n, frame_tick);
        end
        data = 32'hFFFFFFFF; dp = 8'hFF; blank_lz = 1'b1;
        repeat (2) @(posedge sclk);
        #1 reset = 1'b0;
        push_frame(32'h0, 8'h00, 1'b0, 2'd3);
        for (int j = 1; j <= FRAME; j++) begin
            @(posedge sclk); #1;
            e = sb.pop_front();
            checks++;
            if ({en, dis, dp_n, frame_tick} !== e) begin
                failures++;
                $display("FAIL rstmid j=%0d en=%h dis=%h dp_n=%b tick=%b required %h/%h/%b/%b",
                         j, en, dis, dp_n, frame_tick, e.en, e.dis, e.dp_n, e.tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_leading_zero();
        test_hold();
        test_brightness();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display driver for the board debug display. It replaces the external divided scan clock with an internal prescaler on sclk, so the whole block runs in one clock domain. It adds a per-frame data snapshot (tear-free), a hold/freeze input, leading-zero blanking, per-digit decimal points, PWM brightness and a frame-tick output. It sits between the debug-data select mux and the board enable/segment pins.

Parameters:
DIGITS, 8, number of digits scanned; legal range 1..16.
SCAN_DIV, 100000, sclk cycles per digit slot; must be >= 2.
BRIGHT_W, 4, width of the brightness control.

Ports:
sclk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
data  in  4*DIGITS  hex nibbles; nibble i drives digit i (digit 0 is least significant).
dp  in  DIGITS  decimal-point request per digit, 1 = lit.
blank_lz  in  1  1 = suppress leading zeros.
hold  in  1  1 = freeze the current snapshot.
bright  in  BRIGHT_W  brightness level (PWM duty).
en  out  DIGITS  digit enables, active-low, registered.
dis  out  7  segments, active-low, registered; dis[0]=a … dis[6]=g.
dp_n  out  1  decimal point, active-low, registered.
frame_tick  out  1  one-cycle pulse at each frame start, registered.

Behaviour:
- Reset values (asserted asynchronously, no clock needed): en = all ones, dis = 7'h7F, dp_n = 1, frame_tick = 0. Internal state also resets: prescaler = 0, digit index idx = 0, pwm counter = 0, snapshot (data, dp, blank_lz) = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0.
  - Frame period is DIGITS*SCAN_DIV cycles.
- Frame wrap edge (idx DIGITS-1 -> 0):
  - frame_tick = 1 for exactly one cycle, aligned to the cycle in which idx reads 0.
  - If hold = 0, the snapshot loads data, dp and blank_lz on the same edge.
  - If hold = 1, the snapshot is unchanged.
  - Snapshot never loads mid-frame.
- bright is used live, not snapshotted.
- PWM:
  - Free-running BRIGHT_W-bit counter, increments every sclk and wraps naturally.
  - Digit is "on" when pwm_cnt <= bright.
  - bright = 0 gives 1/2^BRIGHT_W duty; bright = all ones gives full duty.
- Leading-zero blanking (from snapshot):
  - Digit i > 0 is blanked when blank_lz = 1 and nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
- Output register, updated every cycle from current idx, pwm_cnt and snapshot (one-cycle latency after any idx/pwm change):
  - en: bit idx = 0 only if the digit is on and not blanked; all other bits = 1.
  - dis: hex decode of nibble idx (0-F standard glyphs, b/d lowercase). dis = 7'h7F whenever the digit is off or blanked.
  - dp_n: ~dp[idx] when the digit is on and not blanked, else 1.
- At most one en bit is low at any time, always.
- Reset asserted mid-frame: immediate return to reset values. After deassertion, scanning restarts at idx 0; the first snapshot loads at the first frame wrap, so all-zero data is shown until then.

Decomposition:
- Package seg7_pkg:
  - SEG_OFF = 7'h7F.
  - 16-entry hex glyph constants (active-low).
  - Function clog2 for prescaler / idx widths.
- Sub-module seg7_hex_dec: purely combinational 4-bit -> 7-segment active-low decoder.
- Prescaler, PWM, snapshot, blanking and the output register stay in seg7_scan_ctrl.

Test Plan:
All scenarios use DIGITS=8, SCAN_DIV=4, BRIGHT_W=2.
- Reset: assert reset with sclk stopped -> en=8'hFF, dis=7'h7F, dp_n=1, frame_tick=0; after release, frame_tick pulses every 32 cycles.
- Basic scan: data=32'h12345678, bright=3, blank_lz=0, wait one frame_tick.
  - Digit 0 slot: en=8'hFE, dis=7'h00.
  - Digit 7 slot: en=8'h7F, dis=7'h79.
  - Digit 3 with dp=8'h08: dp_n=0 only in the digit 3 slot.
- Leading-zero: data=32'h000000A0, blank_lz=1, after frame_tick -> en stays 8'hFF during digit 7..2 slots; digit 1 shows dis=7'h08; digit 0 shows dis=7'h40.
- Hold: load 32'h11111111, set hold=1, change data to 32'h22222222 -> display stays 1s across 3 frames. Clear hold -> 2s appear from the next frame_tick, never mid-frame.
- Brightness: bright=0 -> within each slot, en low for exactly 1 of every 4 cycles. bright=2 -> 3 of 4 cycles. dis=7'h7F whenever en is all ones.
- Reset mid-frame: assert during the digit 5 slot -> outputs reset asynchronously. After release, the first digit shown is digit 0 with all-zero data (dis=7'h40).
